uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART receiver. Captures each received byte
//  on the rising edge of the receiver's data-ready level and queues it in a DEPTH-entry
//  FIFO. Presents bytes to the consumer over a valid/ready handshake.
//  Flags bytes lost to a full queue with a sticky overrun bit.
// PARAMETERS
//  BITS   8   word width; matches the receiver's BITS
//  DEPTH  16  FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1                  single clock; all logic on posedge
//  rst          in   1                  synchronous, active-high reset
//  rx_data      in   BITS               receiver data output (held stable while rx_ready high)
//  rx_ready     in   1                  receiver data_ready level (stays high until next start bit)
//  out_data     out  BITS               head-of-queue word; valid only while out_valid=1
//  out_valid    out  1                  queue non-empty
//  out_ready    in   1                  consumer accepts head this cycle
//  count        out  $clog2(DEPTH+1)    current occupancy, 0..DEPTH
//  full         out  1                  count==DEPTH
//  overrun      out  1                  sticky: a byte was dropped because queue was full
//  clr_overrun  in   1                  clears overrun
// BEHAVIOUR
//  Reset: rd_ptr=wr_ptr=0, count=0, out_valid=0, full=0, overrun=0, rx_ready_q=1.
//   Memory contents not reset; out_data undefined while out_valid=0.
//  Edge detect: rx_ready_q <= rx_ready every cycle. push_req = rx_ready & ~rx_ready_q.
//   rx_ready_q resets to 1, so a level already high (or X) at reset never pushes.
//   Exactly one push per low->high transition; a held-high level never pushes again.
//  Pop: pop = out_valid & out_ready. out_ready while out_valid=0 is ignored.
//  Push accepted when push_req & (~full | pop); mem[wr_ptr] <= rx_data, wr_ptr++.
//  Pop: rd_ptr++. Pointers are $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
//  count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  Outputs derived from registered state: out_valid=(count!=0), full=(count==DEPTH),
//   out_data=mem[rd_ptr] (show-ahead).
//  Latency: rx_ready rises before edge N; push at edge N; out_valid=1 and out_data=rx_data
//   after edge N+1.
//   The N+1 is the edge-detect register: rx_ready sampled high at N with rx_ready_q low
//   -> write at N+1.
//  Simultaneous cases:
//   - empty + push_req: push, no pop (out_valid was 0).
//   - full + push_req + pop: both happen, count stays DEPTH, no overrun.
//   - full + push_req, no pop: byte dropped, queue unchanged, overrun <= 1.
//  overrun: set by a drop; cleared by clr_overrun; set wins if both occur in the same cycle.
//  Reset mid-operation: queue emptied immediately, pending edge forgotten.
//   A rx_ready still high after reset is not re-captured.
//  No internal state machine beyond pointers/count; no combinational path rx_* -> out_*.
// TESTING
//  1 Reset with rx_ready=1 held -> no push; count=0, out_valid=0 for 10 cycles.
//  2 Pulse rx_ready low->high with rx_data=8'hA5, out_ready=0 -> count=1 and
//    out_data=8'hA5 two edges later; held-high rx_ready causes no further push.
//  3 Push 16 bytes 8'h00..8'h0F, then a 17th (8'hFF) -> full=1, overrun=1, count=16;
//    drain reads 00..0F in order, 8'hFF never appears.
//  4 Full queue, push_req and out_ready in the same cycle -> count stays 16,
//    overrun stays 0, new byte appears last after drain.
//  5 Fill/drain 40 bytes with random out_ready -> every byte delivered exactly once,
//    in order, across pointer wrap.
//  6 overrun=1, assert clr_overrun on the same cycle as another drop -> overrun stays 1;
//    clr alone next cycle -> overrun=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures each rising edge of the receiver's data-ready level into a show-ahead FIFO
// with a valid/ready consumer port and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo #(
  parameter int BITS  = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BITS-1:0]            rx_data,
  input  logic                       rx_ready,
  output logic [BITS-1:0]            out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overrun,
  input  logic                       clr_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_count;
  logic [BITS-1:0] r_data;
  logic            r_rx_q, r_push, r_overrun;
  logic            w_pop, w_push, w_drop;
  assign w_pop  = out_valid & out_ready;
  assign w_push = r_push & (~full | w_pop);
  assign w_drop = r_push & full & ~w_pop;
  assign count     = r_count;
  assign out_valid = r_count != '0;
  assign full      = r_count == CW'(DEPTH);
  assign out_data  = r_mem[r_rd];
  assign overrun   = r_overrun;
  // r_rx_q resets high so a level already asserted at reset is never captured
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_q    <= 1'b1;
      r_push    <= 1'b0;
      r_data    <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_rx_q    <= rx_ready;
      r_push    <= rx_ready & ~r_rx_q;
      r_data    <= rx_data;
      r_wr      <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd      <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_overrun <= w_drop | (r_overrun & ~clr_overrun);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr] <= r_data;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of reset, edge capture latency, full/overrun, simultaneous
// push+pop at full, wrap-around ordering with random back-pressure, and overrun clear priority.
module tb_uart_rx_fifo;
  logic       clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic       rx_ready = 1, out_ready = 0, clr_overrun = 0;
  logic [7:0] out_data;
  logic       out_valid, full, overrun;
  logic [4:0] count;
  int checks = 0, failures = 0;
  logic [7:0] q [$];
  logic [7:0] e;
  int sent, got;
  uart_rx_fifo #(.BITS(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .overrun(overrun), .clr_overrun(clr_overrun)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1;
    tick();
    rx_ready = 0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_count", count, 0);
      chk("reset_valid", out_valid, 0);
    end
    chk("reset_full", full, 0);
    chk("reset_overrun", overrun, 0);
    rx_ready = 0;
    tick();
    rx_data = 8'hA5;
    rx_ready = 1;
    tick();
    chk("lat_n_count", count, 0);
    tick();
    chk("lat_n1_count", count, 1);
    chk("lat_n1_valid", out_valid, 1);
    chk("lat_n1_data", out_data, 8'hA5);
    for (int i = 0; i < 5; i++) tick();
    chk("held_high_count", count, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    rx_ready = 0;
    tick();
    chk("pop_count", count, 0);
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_overrun", overrun, 0);
    push_byte(8'hFF);
    chk("drop_overrun", overrun, 1);
    chk("drop_count", count, 16);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", out_data, i);
      tick();
    end
    out_ready = 0;
    chk("drain_empty", out_valid, 0);
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    chk("clr_overrun", overrun, 0);
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    chk("full2", full, 1);
    rx_data = 8'hAA;
    rx_ready = 1;
    tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    rx_ready = 0;
    chk("pushpop_count", count, 16);
    chk("pushpop_overrun", overrun, 0);
    out_ready = 1;
    for (int i = 1; i < 16; i++) begin
      chk("pushpop_drain", out_data, 8'h10 + i);
      tick();
    end
    chk("pushpop_last", out_data, 8'hAA);
    tick();
    out_ready = 0;
    chk("pushpop_empty", count, 0);
    sent = 0;
    got = 0;
    for (int c = 0; c < 1000 && got < 40; c++) begin
      out_ready = $urandom_range(3, 0) != 0;
      if (sent < 40 && !rx_ready) begin
        rx_data = 8'(8'h40 + sent);
        q.push_back(rx_data);
        sent++;
        rx_ready = 1;
      end else rx_ready = 0;
      if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("wrap_data", out_data, e);
        got++;
      end
      tick();
    end
    out_ready = 0;
    rx_ready = 0;
    chk("wrap_got", got, 40);
    chk("wrap_overrun", overrun, 0);
    tick();
    tick();
    chk("wrap_empty", count, 0);
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
    push_byte(8'h55);
    chk("ovr_set", overrun, 1);
    rx_data = 8'h66;
    rx_ready = 1;
    tick();
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    rx_ready = 0;
    chk("ovr_set_wins", overrun, 1);
    chk("ovr_count", count, 16);
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    chk("ovr_clr_alone", overrun, 0);
    chk("ovr_head", out_data, 8'h80);
    rst = 1;
    tick();
    rst = 0;
    chk("midreset_count", count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
